// File: rtl/rom_port_arb_pkg.sv
// Shared program-ROM geometry and owner encoding for the IF/LD ROM port arbiter.
package rom_port_arb_pkg;

    localparam int unsigned ROM_AW   = 10;
    localparam int unsigned ROM_DW   = 16;
    localparam int unsigned STREAK_W = 3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } own_t;

endpackage

// File: rtl/rom_port_arb_rsp_hold.sv
// Per-port response stage: flags the returning ROM word and keeps it visible until the next one.
module rom_rsp_hold
    import rom_port_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RES,
    input  logic              sel,
    input  logic [ROM_DW-1:0] ROM_DATA,
    output logic              VLD,
    output logic [ROM_DW-1:0] DATA
);

    logic [ROM_DW-1:0] hold;

    assign VLD  = sel & ~RES;
    assign DATA = VLD ? ROM_DATA : hold;

    always_ff @(posedge CLK) begin
        if (RES) begin
            hold <= '0;
        end else if (VLD) begin
            hold <= ROM_DATA;
        end
    end

endmodule

// File: rtl/rom_port_arb.sv
// Shares the registered-read program ROM between instruction fetch and data loads;
// loads win contention until a bounded streak forces a fetch through.
module rom_port_arb
    import rom_port_arb_pkg::*;
#(
    parameter int unsigned MAX_LD_STREAK = 2
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              IF_REQ,
    input  logic [ROM_AW-1:0] IF_ADDR,
    output logic              IF_ACK,
    output logic              IF_VLD,
    output logic [ROM_DW-1:0] IF_DATA,
    input  logic              LD_REQ,
    input  logic [ROM_AW-1:0] LD_ADDR,
    output logic              LD_ACK,
    output logic              LD_VLD,
    output logic [ROM_DW-1:0] LD_DATA,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [ROM_DW-1:0] ROM_DATA
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LD_STREAK);

    own_t                own;
    logic [STREAK_W-1:0] ld_streak;
    logic [ROM_AW-1:0]   last_addr;
    logic                streak_full;

    // Grant depends only on REQs and the registered streak, never on ROM_DATA.
    assign streak_full = (ld_streak == STREAK_MAX);
    assign LD_ACK      = ~RES & LD_REQ & ~(IF_REQ & streak_full);
    assign IF_ACK      = ~RES & IF_REQ & ~LD_ACK;

    always_comb begin
        ROM_ADDR = last_addr;
        if (LD_ACK) begin
            ROM_ADDR = LD_ADDR;
        end else if (IF_ACK) begin
            ROM_ADDR = IF_ADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            own       <= OWN_NONE;
            ld_streak <= '0;
            last_addr <= '0;
        end else begin
            own       <= LD_ACK ? OWN_LD : (IF_ACK ? OWN_IF : OWN_NONE);
            last_addr <= ROM_ADDR;
            if (IF_ACK || !IF_REQ) begin
                ld_streak <= '0;
            end else if (LD_ACK && !streak_full) begin
                ld_streak <= ld_streak + STREAK_W'(1);
            end
        end
    end

    rom_rsp_hold u_if_rsp (
        .CLK      (CLK),
        .RES      (RES),
        .sel      (own == OWN_IF),
        .ROM_DATA (ROM_DATA),
        .VLD      (IF_VLD),
        .DATA     (IF_DATA)
    );

    rom_rsp_hold u_ld_rsp (
        .CLK      (CLK),
        .RES      (RES),
        .sel      (own == OWN_LD),
        .ROM_DATA (ROM_DATA),
        .VLD      (LD_VLD),
        .DATA     (LD_DATA)
    );

endmodule

// File: tb/tb_rom_port_arb.sv
// Directed cycle-table bench for rom_port_arb with a registered-read ROM model.
module tb_rom_port_arb;

    logic        CLK = 1'b0;
    logic        RES;
    logic        IF_REQ, LD_REQ;
    logic [9:0]  IF_ADDR, LD_ADDR;
    logic        IF_ACK, LD_ACK, IF_VLD, LD_VLD;
    logic [15:0] IF_DATA, LD_DATA;
    logic [9:0]  ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic [15:0] rom [1024];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    rom_port_arb #(.MAX_LD_STREAK(2)) dut (
        .CLK      (CLK),
        .RES      (RES),
        .IF_REQ   (IF_REQ),
        .IF_ADDR  (IF_ADDR),
        .IF_ACK   (IF_ACK),
        .IF_VLD   (IF_VLD),
        .IF_DATA  (IF_DATA),
        .LD_REQ   (LD_REQ),
        .LD_ADDR  (LD_ADDR),
        .LD_ACK   (LD_ACK),
        .LD_VLD   (LD_VLD),
        .LD_DATA  (LD_DATA),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA)
    );

    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    typedef struct {
        logic        res;
        logic        if_req;
        logic [9:0]  if_addr;
        logic        ld_req;
        logic [9:0]  ld_addr;
        logic        if_ack;
        logic        ld_ack;
        logic        if_vld;
        logic        ld_vld;
        logic [15:0] if_data;
        logic [15:0] ld_data;
        logic [9:0]  rom_addr;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic iq, input int ia, input logic lq, input int la,
                                input logic ik, input logic lk, input logic iv, input logic lv,
                                input logic [15:0] idt, input logic [15:0] ldt, input int ra);
        vec_t v;
        v.res = r; v.if_req = iq; v.if_addr = 10'(ia); v.ld_req = lq; v.ld_addr = 10'(la);
        v.if_ack = ik; v.ld_ack = lk; v.if_vld = iv; v.ld_vld = lv;
        v.if_data = idt; v.ld_data = ldt; v.rom_addr = 10'(ra);
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 16'(i) ^ 16'h5a5a;
        rom[1] = 16'ha000; rom[2] = 16'ha101; rom[17] = 16'h6880; rom[18] = 16'h6010;

        //           res iq ia  lq la   ik lk iv lv  if_data   ld_data   rom
        // reset with both requesting
        vecs.push_back(mk(1, 1, 1, 1, 17, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 1, 1, 17, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 1, 1, 17, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
        // single fetch, then five idle cycles
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'ha000, 16'h0000, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'ha000, 16'h0000, 1));
        // contention: LD, LD, then IF forced through
        vecs.push_back(mk(0, 1, 2, 1, 17, 0, 1, 0, 0, 16'ha000, 16'h0000, 17));
        vecs.push_back(mk(0, 1, 2, 1, 18, 0, 1, 0, 1, 16'ha000, 16'h6880, 18));
        vecs.push_back(mk(0, 1, 2, 1, 17, 1, 0, 0, 1, 16'ha000, 16'h6010, 2));
        vecs.push_back(mk(0, 0, 0, 1, 17, 0, 1, 1, 0, 16'ha101, 16'h6010, 17));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'ha101, 16'h6880, 17));
        // alternating back-to-back, holds stay independent
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 16'ha101, 16'h6880, 1));
        vecs.push_back(mk(0, 0, 0, 1, 17, 0, 1, 1, 0, 16'ha000, 16'h6880, 17));
        vecs.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0, 1, 16'ha000, 16'h6880, 2));
        vecs.push_back(mk(0, 0, 0, 1, 18, 0, 1, 1, 0, 16'ha101, 16'h6880, 18));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'ha101, 16'h6010, 18));
        // idle address hold
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'ha101, 16'h6010, 18));
        // reset mid-flight: clean reset, LD grant, reset in the response cycle
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'ha101, 16'h6010, 18));
        vecs.push_back(mk(0, 0, 0, 1, 17, 0, 1, 0, 0, 16'h0000, 16'h0000, 17));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 17));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0));

        RES = 1'b1; IF_REQ = 1'b1; IF_ADDR = 10'd1; LD_REQ = 1'b1; LD_ADDR = 10'd17;
        @(posedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RES = vecs[i].res; IF_REQ = vecs[i].if_req; IF_ADDR = vecs[i].if_addr;
            LD_REQ = vecs[i].ld_req; LD_ADDR = vecs[i].ld_addr;
            #1;
            chk("if_ack", i, 16'(IF_ACK), 16'(vecs[i].if_ack));
            chk("ld_ack", i, 16'(LD_ACK), 16'(vecs[i].ld_ack));
            chk("if_vld", i, 16'(IF_VLD), 16'(vecs[i].if_vld));
            chk("ld_vld", i, 16'(LD_VLD), 16'(vecs[i].ld_vld));
            chk("if_data", i, IF_DATA, vecs[i].if_data);
            chk("ld_data", i, LD_DATA, vecs[i].ld_data);
            chk("rom_addr", i, 16'(ROM_ADDR), 16'(vecs[i].rom_addr));
        end

        // Sustained contention: IF steps through addresses, LD streams; expect LD,LD,IF repeating.
        begin
            int if_a;
            logic prev_if, prev_ld;
            logic [15:0] exp_d;
            if_a = 40; prev_if = 1'b0; prev_ld = 1'b0; exp_d = 16'h0;
            for (int c = 0; c < 10; c++) begin
                @(negedge CLK);
                RES = 1'b0; IF_REQ = 1'b1; IF_ADDR = 10'(if_a);
                LD_REQ = 1'b1; LD_ADDR = 10'(100 + c);
                #1;
                chk("seq_if_ack", 100 + c, 16'(IF_ACK), 16'((c % 3) == 2));
                chk("seq_ld_ack", 100 + c, 16'(LD_ACK), 16'((c % 3) != 2));
                chk("seq_if_vld", 100 + c, 16'(IF_VLD), 16'(prev_if));
                chk("seq_ld_vld", 100 + c, 16'(LD_VLD), 16'(prev_ld));
                if (prev_if) chk("seq_if_data", 100 + c, IF_DATA, exp_d);
                prev_if = ((c % 3) == 2);
                prev_ld = ((c % 3) != 2);
                if (prev_if) begin
                    exp_d = rom[if_a];
                    if_a++;
                end
            end
            // Dropping IF clears the streak: after IF returns, LD wins twice again.
            @(negedge CLK);
            IF_REQ = 1'b0; LD_REQ = 1'b1; LD_ADDR = 10'd5;
            #1 chk("drop_ld_ack", 200, 16'(LD_ACK), 16'd1);
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                IF_REQ = 1'b1; IF_ADDR = 10'd7; LD_REQ = 1'b1; LD_ADDR = 10'd6;
                #1 chk("drop_if_ack", 201 + c, 16'(IF_ACK), 16'(c == 2));
            end
            @(negedge CLK);
            IF_REQ = 1'b0; LD_REQ = 1'b0;
            #1 chk("drop_if_vld", 204, 16'(IF_VLD), 16'd1);
            chk("drop_if_data", 204, IF_DATA, rom[7]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_port_arb.md
# rom_port_arb

Two-port arbiter that shares the single-port, registered-read 1K x 16 program ROM between the instruction-fetch path (IF) and the program-memory data-load path (LD), such as constant and table reads. It sits between the core and the ROM instance. It drives the ROM address from the granted requester and routes the returned word back to its owner, tagged with a one-cycle valid pulse. LD has priority, bounded by a streak limit, so fetch is never starved.

## Interface
- `MAX_LD_STREAK`, default 2: maximum consecutive LD grants while IF is pending before IF is forced through. Legal range 1..7.
- `CLK` in 1: sole clock; all state updates on posedge.
- `RES` in 1: synchronous, active-high reset.
- `IF_REQ` in 1: fetch request; held with `IF_ADDR` stable until `IF_ACK`.
- `IF_ADDR` in 10: fetch word address.
- `IF_ACK` out 1: combinational grant; the request is accepted on this cycle's edge.
- `IF_VLD` out 1: one-cycle pulse; `IF_DATA` carries the requested word.
- `IF_DATA` out 16: fetch data; stable from `IF_VLD` until the next `IF_VLD`.
- `LD_REQ`, `LD_ADDR`, `LD_ACK`, `LD_VLD`, `LD_DATA`: same widths and rules as the IF set, for the load port.
- `ROM_ADDR` out 10: address to the ROM, sampled by the ROM on posedge.
- `ROM_DATA` in 16: ROM output, valid the cycle after the address is sampled.

## Operation
- Grant rule, evaluated per cycle with `RES` low:
  - If only one requester is active, that requester is granted.
  - If both are active, LD wins unless `ld_streak == MAX_LD_STREAK`; in that case IF wins.
  - At most one ACK is high in any cycle.
- `ld_streak` (3-bit):
  - Increments on an LD grant while `IF_REQ` is high, saturating at `MAX_LD_STREAK`.
  - Clears on any IF grant, or in any cycle where `IF_REQ` is low.
- `ROM_ADDR` is the granted address. With no grant it holds the last granted address (`last_addr` register) so the ROM does not toggle.
- Owner register `own` takes one of three values: `NONE`, `IF`, `LD`. It is loaded each edge with the granted port, or `NONE` if nothing was granted.
- Response, cycle after a grant:
  - `X_VLD = (own == X) & ~RES`.
  - `X_DATA = X_VLD ? ROM_DATA : hold_X`.
  - `hold_X` captures `ROM_DATA` on that edge.
- Back-to-back grants are allowed every cycle (full throughput). Alternating owners are supported; each port's hold register is independent.
- Reset values:
  - `own = NONE`, `ld_streak = 0`, `last_addr = 0`, `hold_IF = hold_LD = 0`.
  - Hence after reset: `IF_VLD = LD_VLD = 0`, `IF_DATA = LD_DATA = 0`, `ROM_ADDR = 0`.
- While `RES` is high: `IF_ACK = LD_ACK = 0`, and `X_VLD = 0`.
- A reset in the response cycle drops that response; no late VLD follows reset release.
- A requester whose ACK was suppressed by reset must keep its REQ and ADDR held.

## Timing
- Cycle t: REQ high and ACK high (combinational). `ROM_ADDR = X_ADDR`. ROM samples at the end of t.
- Cycle t+1: `ROM_DATA` is valid. `X_VLD = 1`, `X_DATA = ROM[X_ADDR]`. Latency is exactly 1 cycle from ACK to VLD.
- `X_DATA` stays at that value from t+1 until the next `X_VLD`, including across idle cycles.
- ACK paths are combinational from REQ and the registered `ld_streak` only. There is no path from `ROM_DATA` to any ACK.
- A requester may drop REQ, or change ADDR, only on the edge where ACK was high.

## Structure
- The core-shared package holds:
  - `ROM_AW = 10` and `ROM_DW = 16`.
  - The owner encoding `OWN_NONE = 2'd0`, `OWN_IF = 2'd1`, `OWN_LD = 2'd2`.
- One natural sub-module, `rom_rsp_hold`, instantiated once per port. It contains the hold register plus the VLD/DATA mux (inputs: `CLK`, `RES`, `sel`, `ROM_DATA`).
- The ROM itself is instantiated by the parent, not inside this block.

## Test plan
Use the standard program image, where `ROM[1]=16'ha000`, `ROM[2]=16'ha101`, `ROM[17]=16'h6880`, `ROM[18]=16'h6010`.

- **Reset:** hold `RES` high 3 cycles with both REQs high. Required: both ACK = 0, both VLD = 0, both DATA = 0, `ROM_ADDR = 0`.
- **Single fetch:** `IF_REQ` high with addr 1 for one cycle. Required: `IF_ACK` = 1 in the same cycle, `IF_VLD` pulses the next cycle with `16'ha000`, and `IF_DATA` stays `16'ha000` for 5 idle cycles.
- **Contention:** IF holds addr 2 while LD requests addr 17, then addr 18, then addr 17, continuously (`MAX_LD_STREAK = 2`).
  - Required: LD granted twice in a row, then IF granted.
  - `IF_VLD` carries `16'ha101` in the 3rd response cycle.
  - `LD_DATA` = `16'h6880`, then `16'h6010`.
- **Alternating back-to-back:** IF addr 1 and LD addr 17 on consecutive cycles. Required: VLDs on consecutive cycles, each DATA correct, and neither hold register corrupted by the other port.
- **Reset mid-flight:** grant LD addr 17, then assert `RES` in the response cycle. Required: `LD_VLD` stays 0 and `LD_DATA = 0`; after release, no stale VLD appears.
- **Idle address hold:** after a grant of addr 18, drive no requests for 4 cycles. Required: `ROM_ADDR` stays 18 and no VLD is asserted.
